matrix_job_arbiter: RTL and testbench
=====================================

MATRIX_JOB_ARBITER -- requirements
Module: matrix_job_arbiter

Interface
REQ-001 SHALL have parameter W, default 12: fixed-point (12:10) element width.
REQ-002 SHALL have parameter N_REQ, default 4: number of requesters (2..8).
REQ-003 SHALL have parameter TIMEOUT, default 64: watchdog limit in cycles.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  N_REQ  per-requester job request.
REQ-007 req_ready  out  N_REQ  per-requester accept pulse.
REQ-008 req_a, req_b  in  [N_REQ-1:0][15:0][W-1:0] each  operand matrices; column c is elements 4c..4c+3, row-ordered.
REQ-009 mu_valid  out  1  job start to compute unit.
REQ-010 mu_a, mu_b  out  [15:0][W-1:0] each  operands to compute unit, same layout.
REQ-011 mu_res_valid  in  1  compute unit result valid.
REQ-012 mu_res_ready  out  1  result accept to compute unit.
REQ-013 mu_c  in  [15:0][W-1:0]  compute unit result.
REQ-014 rsp_valid/rsp_ready  out/in  1/1  response handshake.
REQ-015 rsp_id  out  $clog2(N_REQ)  requester index of the response.
REQ-016 rsp_c  out  [15:0][W-1:0]  result matrix.
REQ-017 rsp_err  out  1  response aborted by watchdog.
REQ-018 err_timeout  out  1  sticky watchdog flag.
REQ-019 job_count  out  16  completed jobs, wraps at 2^16.

Function
REQ-020 FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-021 IDLE: if any req_valid, SHALL grant round-robin (first valid index after last granted, wrapping modulo N_REQ; after reset the search starts at index 0), pulse req_ready[grant] for 1 cycle, latch req_a/req_b into operand registers, record the id, and go to ISSUE; otherwise stay in IDLE.
REQ-022 At most one req_ready bit SHALL be high in any cycle, and only in IDLE.
REQ-023 ISSUE: mu_valid=1 for exactly 1 cycle, clear the watchdog, then go to WAIT.
REQ-024 mu_a/mu_b SHALL be driven from the operand registers and held stable from ISSUE until leaving WAIT, because the compute unit reads its operands every cycle while busy.
REQ-025 WAIT: mu_res_ready=1; on mu_res_valid=1, latch mu_c into rsp_c, set rsp_err=0, increment job_count, and go to RESP.
REQ-026 WAIT: the watchdog increments each cycle; if it reaches TIMEOUT without mu_res_valid, set err_timeout=1, rsp_c=0 and rsp_err=1, and go to RESP.
REQ-027 mu_res_valid outside WAIT SHALL be ignored.
REQ-028 RESP: rsp_valid=1 with stable rsp_id/rsp_c/rsp_err until rsp_ready=1, then go to IDLE.
REQ-029 A new grant SHALL NOT occur before the cycle after the RESP handshake, giving minimum 2 cycles between a result capture and the next mu_valid.
REQ-030 Latency from grant to rsp_valid SHALL be compute latency + 2 cycles (ISSUE cycle plus capture edge).
REQ-031 Requests deasserted before grant SHALL be dropped without side effects; requests held during a busy job SHALL wait.
REQ-032 The round-robin pointer SHALL update only on grant.

Reset
REQ-033 rst=1 SHALL force IDLE with pointer at the last index (next search starts at 0), and req_ready=0, mu_valid=0, mu_res_ready=0, rsp_valid=0, rsp_err=0, err_timeout=0, job_count=0, rsp_c=0, operand registers=0.
REQ-034 Reset mid-job SHALL abandon the job with no response; the next job SHALL start only after rst=0.

Verification
REQ-035 Single job: req_valid[2]=1, A all 1, B all 2, model unit latency 18 -> req_ready[2] pulse, one mu_valid pulse, rsp_id=2, every rsp_c element 8, job_count=1.
REQ-036 Fairness: all four req_valid held high for 8 jobs -> grant order 0,1,2,3,0,1,2,3, and rsp_id follows the same order.
REQ-037 Stall: hold rsp_ready=0 for 10 cycles after rsp_valid -> rsp outputs stable, no req_ready or mu_valid pulses, resume on rsp_ready=1.
REQ-038 Timeout: model never asserts mu_res_valid -> after 64 WAIT cycles rsp_valid=1, rsp_err=1, rsp_c=0, and err_timeout stays 1 through later good jobs until rst.
REQ-039 Reset mid-WAIT: rst at WAIT cycle 5 -> all outputs at reset values next cycle, no rsp_valid, and the next request from index 0 is granted normally.
REQ-040 Operand hold: change req_a of the granted requester after grant -> mu_a unchanged until capture, and the result matches the latched operands.

Source files
------------

// File: rtl/matrix_job_arbiter.sv
// Round-robin arbiter that feeds 4x4 matrix jobs to one shared compute unit
// and returns each result (or a watchdog abort) to the requester.
module matrix_job_arbiter #(
  parameter int W       = 12,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req_valid,
  output logic [N_REQ-1:0]                 req_ready,
  input  logic [N_REQ-1:0][15:0][W-1:0]    req_a,
  input  logic [N_REQ-1:0][15:0][W-1:0]    req_b,
  output logic                             mu_valid,
  output logic [15:0][W-1:0]               mu_a,
  output logic [15:0][W-1:0]               mu_b,
  input  logic                             mu_res_valid,
  output logic                             mu_res_ready,
  input  logic [15:0][W-1:0]               mu_c,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [$clog2(N_REQ)-1:0]         rsp_id,
  output logic [15:0][W-1:0]               rsp_c,
  output logic                             rsp_err,
  output logic                             err_timeout,
  output logic [15:0]                      job_count
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [IW-1:0]        ptr;
  logic [IW-1:0]        cand [N_REQ];
  logic                 gnt_any;
  logic [IW-1:0]        gnt_id;
  logic [CW-1:0]        wdog;
  logic [15:0][W-1:0]   op_a;
  logic [15:0][W-1:0]   op_b;
  logic                 grant;
  logic                 capture;
  logic                 expire;

  // search order: ptr+1, ptr+2, ... wrapping
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      cand[i] = IW'((int'(ptr) + i + 1) % N_REQ);
    end
  end

  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_any && req_valid[cand[i]]) begin
        gnt_any = 1'b1;
        gnt_id  = cand[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    req_ready    = '0;
    mu_valid     = 1'b0;
    mu_res_ready = 1'b0;
    rsp_valid    = 1'b0;
    grant        = 1'b0;
    capture      = 1'b0;
    expire       = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            grant     = 1'b1;
            req_ready = N_REQ'(1) << gnt_id;
            state_nxt = ISSUE;
          end
        end
        ISSUE: begin
          mu_valid  = 1'b1;
          state_nxt = WAIT;
        end
        WAIT: begin
          mu_res_ready = 1'b1;
          if (mu_res_valid) begin
            capture   = 1'b1;
            state_nxt = RESP;
          end else if (wdog == CW'(TIMEOUT - 1)) begin
            expire    = 1'b1;
            state_nxt = RESP;
          end
        end
        RESP: begin
          rsp_valid = 1'b1;
          if (rsp_ready) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // operands stay put from grant until the next grant
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= IW'(N_REQ - 1);
      rsp_id      <= '0;
      op_a        <= '0;
      op_b        <= '0;
      wdog        <= '0;
      rsp_c       <= '0;
      rsp_err     <= 1'b0;
      err_timeout <= 1'b0;
      job_count   <= '0;
    end else begin
      if (grant) begin
        ptr    <= gnt_id;
        rsp_id <= gnt_id;
        op_a   <= req_a[gnt_id];
        op_b   <= req_b[gnt_id];
      end
      if (mu_valid) begin
        wdog <= '0;
      end else if (mu_res_ready) begin
        wdog <= wdog + CW'(1);
      end
      if (capture) begin
        rsp_c     <= mu_c;
        rsp_err   <= 1'b0;
        job_count <= job_count + 16'd1;
      end
      if (expire) begin
        rsp_c       <= '0;
        rsp_err     <= 1'b1;
        err_timeout <= 1'b1;
      end
    end
  end

  assign mu_a = op_a;
  assign mu_b = op_b;

endmodule

// File: tb/tb_matrix_job_arbiter.sv
// Bench for matrix_job_arbiter: job-level reference model, compute unit
// stand-in, directed scenarios and a randomized soak.
module tb_matrix_job_arbiter;

  localparam int W  = 12;
  localparam int N  = 4;
  localparam int TO = 64;

  typedef logic [15:0][W-1:0] mat_t;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [N-1:0]              req_valid;
  logic [N-1:0]              req_ready;
  logic [N-1:0][15:0][W-1:0] req_a;
  logic [N-1:0][15:0][W-1:0] req_b;
  logic                      mu_valid;
  mat_t                      mu_a;
  mat_t                      mu_b;
  logic                      mu_res_valid;
  logic                      mu_res_ready;
  mat_t                      mu_c;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [1:0]                rsp_id;
  mat_t                      rsp_c;
  logic                      rsp_err;
  logic                      err_timeout;
  logic [15:0]               job_count;

  matrix_job_arbiter #(.W(W), .N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mu_valid(mu_valid), .mu_a(mu_a), .mu_b(mu_b),
    .mu_res_valid(mu_res_valid), .mu_res_ready(mu_res_ready),
    .mu_c(mu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_c(rsp_c), .rsp_err(rsp_err),
    .err_timeout(err_timeout), .job_count(job_count)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int lat_fixed = -1;
  int unit_lat = 0;
  bit spur_en = 1'b1;

  function automatic mat_t matmul(input mat_t a, input mat_t b);
    mat_t c;
    logic [W-1:0] s;
    c = '0;
    for (int r = 0; r < 4; r++) begin
      for (int q = 0; q < 4; q++) begin
        s = '0;
        for (int k = 0; k < 4; k++) s = s + a[4*k+r] * b[4*q+k];
        c[4*q+r] = s;
      end
    end
    return c;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // compute unit stand-in: answers unit_lat cycles after mu_valid
  // (0 = never) and reads its operands on the answer cycle
  int ucnt;
  initial begin
    mu_res_valid = 1'b0;
    mu_c = '0;
    ucnt = 0;
    forever begin
      @(posedge clk);
      #2;
      mu_res_valid = 1'b0;
      if (rst) begin
        ucnt = 0;
      end else if (mu_valid) begin
        ucnt = unit_lat;
      end else if (ucnt > 0) begin
        ucnt--;
        if (ucnt == 0) begin
          mu_res_valid = 1'b1;
          mu_c = matmul(mu_a, mu_b);
        end
      end else if (spur_en && !mu_res_ready && $urandom_range(0, 5) == 0) begin
        mu_res_valid = 1'b1;
        for (int e = 0; e < 16; e++) mu_c[e] = W'($urandom);
      end
    end
  end

  // job-level reference model and per-cycle compare
  bit         mbusy = 1'b0;
  bit         jerr;
  bit         msticky = 1'b0;
  bit         mrsp_err = 1'b0;
  int         mlast = N - 1;
  int         gcyc = 0;
  int         endc = 0;
  int         cyc = 0;
  int         win;
  int         t;
  int         lsel;
  int         lat;
  logic [1:0] widx;
  logic [1:0] mrsp_id = '0;
  logic [15:0] mcount = '0;
  mat_t       mop_a = '0;
  mat_t       mop_b = '0;
  mat_t       mrsp_c = '0;
  logic [N-1:0] e_rdy;
  bit         e_muv;
  bit         e_mrr;
  bit         e_rv;

  always @(negedge clk) begin
    if (rst) begin
      chk("quiet_in_rst",
          256'({req_ready, mu_valid, mu_res_ready, rsp_valid}), 256'(0));
      mbusy = 1'b0;
      mlast = N - 1;
      mop_a = '0;
      mop_b = '0;
      mrsp_c = '0;
      mrsp_err = 1'b0;
      msticky = 1'b0;
      mcount = '0;
    end else begin
      e_rdy = '0;
      e_muv = 1'b0;
      e_mrr = 1'b0;
      e_rv = 1'b0;
      win = -1;
      if (!mbusy) begin
        for (int k = 1; k <= N; k++) begin
          t = (mlast + k) % N;
          widx = 2'(t);
          if (win < 0 && req_valid[widx]) win = t;
        end
        if (win >= 0) e_rdy = N'(1) << win;
      end else begin
        e_muv = (cyc == gcyc + 1);
        e_mrr = (cyc > gcyc + 1) && (cyc <= endc);
        e_rv = (cyc > endc);
      end
      chk("req_ready", 256'(req_ready), 256'(e_rdy));
      chk("mu_valid", 256'(mu_valid), 256'(e_muv));
      chk("mu_res_ready", 256'(mu_res_ready), 256'(e_mrr));
      chk("rsp_valid", 256'(rsp_valid), 256'(e_rv));
      chk("mu_a", 256'(mu_a), 256'(mop_a));
      chk("mu_b", 256'(mu_b), 256'(mop_b));
      chk("err_timeout", 256'(err_timeout), 256'(msticky));
      chk("job_count", 256'(job_count), 256'(mcount));
      chk("rsp_c", 256'(rsp_c), 256'(mrsp_c));
      chk("rsp_err", 256'(rsp_err), 256'(mrsp_err));
      if (e_rv) chk("rsp_id", 256'(rsp_id), 256'(mrsp_id));
      if (win >= 0) begin
        widx = 2'(win);
        mbusy = 1'b1;
        mlast = win;
        gcyc = cyc;
        mrsp_id = widx;
        mop_a = req_a[widx];
        mop_b = req_b[widx];
        if (lat_fixed >= 0) begin
          lat = lat_fixed;
        end else begin
          lsel = $urandom_range(0, 19);
          if (lsel == 0) lat = 0;
          else if (lsel == 1) lat = 70;
          else lat = $urandom_range(1, 25);
        end
        unit_lat = lat;
        jerr = (lat == 0) || (lat > TO);
        endc = jerr ? gcyc + 1 + TO : gcyc + 1 + lat;
      end else if (mbusy && cyc == endc) begin
        mrsp_err = jerr;
        if (jerr) begin
          mrsp_c = '0;
          msticky = 1'b1;
        end else begin
          mrsp_c = matmul(mop_a, mop_b);
          mcount++;
        end
      end else if (e_rv && rsp_ready) begin
        mbusy = 1'b0;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_mat(input int id, input int va, input int vb);
    for (int e = 0; e < 16; e++) begin
      req_a[id][e] = W'(va);
      req_b[id][e] = W'(vb);
    end
  endtask

  // sel 0: any req_ready, 1: rsp_valid; n = negedges until seen
  task automatic wait_sig(input int sel, output int n);
    bit hit;
    hit = 1'b0;
    n = 0;
    while (!hit && n < 300) begin
      @(negedge clk);
      n++;
      hit = (sel == 0) ? (|req_ready) : rsp_valid;
    end
    if (!hit) begin
      n_chk++;
      n_err++;
      $display("FAIL wait_%0d: no event within 300 cycles", sel);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int   n;
  int   gseq [8];
  int   rseq [8];
  bit   stable;
  mat_t e8;
  mat_t rc;

  initial begin
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    req_a = '0;
    req_b = '0;
    for (int e = 0; e < 16; e++) e8[e] = W'(8);
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_job_count", 256'(job_count), 256'(0));
    chk("reset_err_timeout", 256'(err_timeout), 256'(0));

    // single job from requester 2
    tick();
    set_mat(2, 1, 2);
    lat_fixed = 18;
    req_valid = 4'b0100;
    wait_sig(0, n);
    chk("single_grant", 256'(req_ready), 256'(4'b0100));
    tick();
    req_valid = '0;
    wait_sig(1, n);
    chk("single_latency", 256'(n), 256'(20));
    chk("single_id", 256'(rsp_id), 256'(2));
    chk("single_c", 256'(rsp_c), 256'(e8));
    tick();
    @(negedge clk);
    chk("single_count", 256'(job_count), 256'(1));

    // fairness with everyone requesting
    do_reset();
    lat_fixed = -1;
    req_valid = 4'hF;
    for (int j = 0; j < 8; j++) begin
      wait_sig(0, n);
      gseq[j] = onehot_idx(req_ready);
      wait_sig(1, n);
      rseq[j] = int'(rsp_id);
    end
    tick();
    req_valid = '0;
    for (int j = 0; j < 8; j++) begin
      chk("fair_grant", 256'(gseq[j]), 256'(j % 4));
      chk("fair_rsp_id", 256'(rseq[j]), 256'(j % 4));
    end

    // response stall
    lat_fixed = 5;
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    wait_sig(0, n);
    tick();
    req_valid = 4'b0010;
    wait_sig(1, n);
    rc = rsp_c;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid || req_ready != '0 || mu_valid || rsp_c !== rc)
        stable = 1'b0;
    end
    chk("stall_hold", 256'(stable), 256'(1));
    tick();
    rsp_ready = 1'b1;
    wait_sig(0, n);
    chk("stall_resume", 256'(req_ready), 256'(4'b0010));
    chk("stall_gap", 256'(n), 256'(2));
    tick();
    req_valid = '0;
    wait_sig(1, n);

    // watchdog abort, then a good job keeps the sticky flag
    lat_fixed = 0;
    req_valid = 4'b0100;
    wait_sig(0, n);
    tick();
    req_valid = '0;
    wait_sig(1, n);
    chk("to_latency", 256'(n), 256'(66));
    chk("to_rsp_err", 256'(rsp_err), 256'(1));
    chk("to_rsp_c", 256'(rsp_c), 256'(0));
    tick();
    lat_fixed = 3;
    req_valid = 4'b1000;
    wait_sig(0, n);
    tick();
    req_valid = '0;
    wait_sig(1, n);
    chk("to_good_err", 256'(rsp_err), 256'(0));
    chk("to_sticky", 256'(err_timeout), 256'(1));

    // reset on the fifth WAIT cycle
    tick();
    lat_fixed = 30;
    req_valid = 4'b0001;
    wait_sig(0, n);
    tick();
    req_valid = '0;
    repeat (4) tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_count", 256'(job_count), 256'(0));
    chk("rstw_sticky", 256'(err_timeout), 256'(0));
    chk("rstw_quiet", 256'({rsp_valid, mu_res_ready}), 256'(0));
    tick();
    req_valid = 4'b0011;
    wait_sig(0, n);
    chk("rstw_regrant", 256'(req_ready), 256'(4'b0001));
    tick();
    req_valid = '0;
    wait_sig(1, n);
    chk("rstw_rsp_id", 256'(rsp_id), 256'(0));

    // operands change right after grant
    tick();
    lat_fixed = 10;
    set_mat(3, 1, 2);
    req_valid = 4'b1000;
    wait_sig(0, n);
    tick();
    set_mat(3, 3, 5);
    req_valid = '0;
    wait_sig(1, n);
    chk("hold_c", 256'(rsp_c), 256'(e8));

    // randomized soak
    lat_fixed = -1;
    repeat (3000) begin
      tick();
      rst = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) req_valid[i] = ~req_valid[i];
        if ($urandom_range(0, 7) == 0) begin
          for (int e = 0; e < 16; e++) begin
            req_a[i][e] = W'($urandom);
            req_b[i][e] = W'($urandom);
          end
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    tick();
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (100) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
